// File: rtl/ctrl_pkg.sv
// Shared types and default constants for the control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam int           DEF_OP_W        = 4;
  localparam logic [3:0]   DEF_JMP_OP      = 4'b0010;
  localparam logic [3:0]   DEF_HLT_OP      = 4'b0011;
  localparam logic [3:0]   DEF_WRREG_OP    = 4'b1010;
  localparam logic [3:0]   DEF_LD_OP       = 4'b0100;
  localparam logic [3:0]   DEF_ST_OP       = 4'b0101;
  localparam int           DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode decode: held opcode -> control flags.
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int              OP_W     = DEF_OP_W,
  parameter logic [OP_W-1:0] JMP_OP   = OP_W'(DEF_JMP_OP),
  parameter logic [OP_W-1:0] HLT_OP   = OP_W'(DEF_HLT_OP),
  parameter logic [OP_W-1:0] WRREG_OP = OP_W'(DEF_WRREG_OP),
  parameter logic [OP_W-1:0] LD_OP    = OP_W'(DEF_LD_OP),
  parameter logic [OP_W-1:0] ST_OP    = OP_W'(DEF_ST_OP)
) (
  input  logic [OP_W-1:0] op,
  output logic            is_jmp,
  output logic            is_hlt,
  output logic            is_mem,
  output logic            wr_reg,
  output logic            wr_cc
);

  assign is_jmp = (op == JMP_OP);
  assign is_hlt = (op == HLT_OP);
  assign is_mem = (op == LD_OP) || (op == ST_OP);
  assign wr_reg = (op == WRREG_OP) || (op == LD_OP);
  // Condition codes follow the opcode MSB, so unknown opcodes still get this rule.
  assign wr_cc  = op[OP_W-1];

endmodule

// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer: opcode handshake, decode, memory wait, strobes, sticky halt.
//   state  | meaning
//   IDLE   | ready for an opcode
//   DECODE | one cycle to classify the held opcode
//   MEM    | memory request outstanding, timeout counter running
//   EXEC   | one cycle of control strobes
//   HALT   | halted until resume
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int              OP_W        = DEF_OP_W,
  parameter logic [OP_W-1:0] JMP_OP      = OP_W'(DEF_JMP_OP),
  parameter logic [OP_W-1:0] HLT_OP      = OP_W'(DEF_HLT_OP),
  parameter logic [OP_W-1:0] WRREG_OP    = OP_W'(DEF_WRREG_OP),
  parameter logic [OP_W-1:0] LD_OP       = OP_W'(DEF_LD_OP),
  parameter logic [OP_W-1:0] ST_OP       = OP_W'(DEF_ST_OP),
  parameter int              MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_opValid,
  output logic            o_opReady,
  input  logic [OP_W-1:0] i_opcode,
  output logic            o_memReq,
  input  logic            i_memDone,
  input  logic            i_resume,
  output logic            o_allowJmp,
  output logic            o_wrReg,
  output logic            o_wrCC,
  output logic            o_isHLT,
  output logic            o_busy,
  output logic            o_timeout
);

  localparam int             CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic dec_jmp, dec_hlt, dec_mem, dec_wr_reg, dec_wr_cc;

  ctrl_op_decode #(
    .OP_W    (OP_W),
    .JMP_OP  (JMP_OP),
    .HLT_OP  (HLT_OP),
    .WRREG_OP(WRREG_OP),
    .LD_OP   (LD_OP),
    .ST_OP   (ST_OP)
  ) u_decode (
    .op    (op_q),
    .is_jmp(dec_jmp),
    .is_hlt(dec_hlt),
    .is_mem(dec_mem),
    .wr_reg(dec_wr_reg),
    .wr_cc (dec_wr_cc)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_opValid) begin
          op_d    = i_opcode;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_hlt) begin
          state_d = ST_HALT;
        end else if (dec_mem) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        // Counter leaves MEM at its terminal value, so it never wraps.
        cnt_d = cnt_q + CNT_W'(1);
        if (i_memDone) begin
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_HALT: begin
        if (i_resume) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_opReady  = (state_q == ST_IDLE);
    o_memReq   = (state_q == ST_MEM);
    o_isHLT    = (state_q == ST_HALT);
    o_busy     = (state_q == ST_DECODE) || (state_q == ST_MEM) || (state_q == ST_EXEC);
    o_allowJmp = (state_q == ST_EXEC) && dec_jmp;
    o_wrReg    = (state_q == ST_EXEC) && dec_wr_reg;
    o_wrCC     = (state_q == ST_EXEC) && dec_wr_cc;
    o_timeout  = timeout_q;
  end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed self-checking bench for ctrl_seq_unit.
module tb_ctrl_seq_unit;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_opValid = 1'b0;
  logic [3:0] i_opcode = 4'b0000;
  logic       i_memDone = 1'b0;
  logic       i_resume = 1'b0;
  logic o_opReady, o_memReq, o_allowJmp, o_wrReg, o_wrCC, o_isHLT, o_busy, o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // obs bits: opReady busy memReq allowJmp wrReg wrCC isHLT timeout
  logic [7:0] obs;
  assign obs = {o_opReady, o_busy, o_memReq, o_allowJmp, o_wrReg, o_wrCC, o_isHLT, o_timeout};

  localparam logic [7:0] E_IDLE  = 8'b1000_0000;
  localparam logic [7:0] E_DEC   = 8'b0100_0000;
  localparam logic [7:0] E_MEM   = 8'b0110_0000;
  localparam logic [7:0] E_WRREG = 8'b0100_1100;
  localparam logic [7:0] E_JMP   = 8'b0101_0000;
  localparam logic [7:0] E_LD    = 8'b0100_1000;
  localparam logic [7:0] E_ST    = 8'b0100_0000;
  localparam logic [7:0] E_HALT  = 8'b0000_0010;
  localparam logic [7:0] E_TOUT  = 8'b1000_0001;

  ctrl_seq_unit dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_opValid (i_opValid),
    .o_opReady (o_opReady),
    .i_opcode  (i_opcode),
    .o_memReq  (o_memReq),
    .i_memDone (i_memDone),
    .i_resume  (i_resume),
    .o_allowJmp(o_allowJmp),
    .o_wrReg   (o_wrReg),
    .o_wrCC    (o_wrCC),
    .o_isHLT   (o_isHLT),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Handshake at the next edge; afterwards the DUT is in DECODE.
  task automatic issue(input logic [3:0] op);
    i_opValid = 1'b1;
    i_opcode  = op;
    step();
    i_opValid = 1'b0;
    i_opcode  = 4'b0000;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    #3;
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, E_IDLE); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_wrreg();
    issue(4'b1010);
    n_checks++; if (obs !== E_DEC) begin n_fail++; $display("FAIL wrreg_t1: got %b want %b", obs, E_DEC); end
    step();
    n_checks++; if (obs !== E_WRREG) begin n_fail++; $display("FAIL wrreg_t2: got %b want %b", obs, E_WRREG); end
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL wrreg_t3: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_jmp();
    issue(4'b0010);
    step();
    n_checks++; if (obs !== E_JMP) begin n_fail++; $display("FAIL jmp_exec: got %b want %b", obs, E_JMP); end
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL jmp_after: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_unknown_op();
    // 4'b1100 is not a named opcode: only the MSB-driven CC write applies.
    issue(4'b1100);
    step();
    n_checks++; if (obs !== 8'b0100_0100) begin n_fail++; $display("FAIL unknown_exec: got %b want %b", obs, 8'b0100_0100); end
    step();
  endtask

  task automatic test_mem(input logic [3:0] op, input logic [7:0] exp_exec, input int done_cycle);
    int mem_cycles;
    issue(op);
    step();
    mem_cycles = 0;
    for (int k = 1; k <= done_cycle; k++) begin
      if (o_memReq === 1'b1) mem_cycles++;
      n_checks++; if (obs !== E_MEM) begin n_fail++; $display("FAIL mem_wait op=%b cyc=%0d: got %b want %b", op, k, obs, E_MEM); end
      if (k == done_cycle) i_memDone = 1'b1;
      step();
      i_memDone = 1'b0;
    end
    n_checks++; if (mem_cycles !== done_cycle) begin n_fail++; $display("FAIL mem_req_len op=%b: got %0d want %0d", op, mem_cycles, done_cycle); end
    n_checks++; if (obs !== exp_exec) begin n_fail++; $display("FAIL mem_exec op=%b: got %b want %b", op, obs, exp_exec); end
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL mem_after op=%b: got %b want %b", op, obs, E_IDLE); end
  endtask

  task automatic test_timeout();
    int mem_cycles;
    issue(4'b0100);
    step();
    mem_cycles = 0;
    for (int k = 1; k <= 15; k++) begin
      if (o_memReq === 1'b1) mem_cycles++;
      if (o_timeout !== 1'b0) begin n_checks++; n_fail++; $display("FAIL tout_early cyc=%0d: got %b want 0", k, o_timeout); end
      step();
    end
    n_checks++; if (mem_cycles !== 15) begin n_fail++; $display("FAIL tout_req_len: got %0d want 15", mem_cycles); end
    n_checks++; if (obs !== E_TOUT) begin n_fail++; $display("FAIL tout_pulse: got %b want %b", obs, E_TOUT); end
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL tout_clear: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_halt();
    issue(4'b0011);
    step();
    i_opValid = 1'b1;
    i_opcode  = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (obs !== E_HALT) begin n_fail++; $display("FAIL halt_hold cyc=%0d: got %b want %b", k, obs, E_HALT); end
      step();
    end
    i_opValid = 1'b0;
    i_resume  = 1'b1;
    step();
    i_resume  = 1'b0;
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL halt_resume: got %b want %b", obs, E_IDLE); end
    i_resume = 1'b1;
    step();
    i_resume = 1'b0;
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL resume_ignored: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_reset_mid_mem();
    issue(4'b0100);
    step();
    step();
    n_checks++; if (obs !== E_MEM) begin n_fail++; $display("FAIL rstmem_pre: got %b want %b", obs, E_MEM); end
    i_rstn = 1'b0;
    #1;
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL rstmem_drop: got %b want %b", obs, E_IDLE); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL rstmem_release: got %b want %b", obs, E_IDLE); end
    test_wrreg();
  endtask

  task automatic test_back_to_back();
    i_opValid = 1'b1;
    i_opcode  = 4'b0010;
    step();
    i_opcode  = 4'b1010;
    step();
    n_checks++; if (obs !== E_JMP) begin n_fail++; $display("FAIL b2b_first: got %b want %b", obs, E_JMP); end
    step();
    n_checks++; if (obs !== E_IDLE) begin n_fail++; $display("FAIL b2b_gap: got %b want %b", obs, E_IDLE); end
    step();
    i_opValid = 1'b0;
    n_checks++; if (obs !== E_DEC) begin n_fail++; $display("FAIL b2b_second_dec: got %b want %b", obs, E_DEC); end
    step();
    n_checks++; if (obs !== E_WRREG) begin n_fail++; $display("FAIL b2b_second: got %b want %b", obs, E_WRREG); end
    step();
  endtask

  initial begin
    test_reset();
    test_wrreg();
    test_jmp();
    test_unknown_op();
    test_mem(4'b0100, E_LD, 3);
    test_mem(4'b0101, E_ST, 3);
    test_timeout();
    test_mem(4'b0100, E_LD, 15);
    test_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
